// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared ISA definitions for the fetch stage.
//   state_t     : fetch FSM states (IDLE / RUN / HALT)
//   pc_sel_t    : which next-PC source the selector picked
//   instr_t     : raw ROM word split into {format, opcode, sign, operand}
//   HALT_WORD   : ROM word that stops fetching once it reaches the IR
//   sext_offset : sign-extends a branch offset to PC width
package fetch_unit_pkg;

    localparam int PC_W      = 16;
    localparam int OFFSET_W  = 8;
    localparam int INSTR_W   = 9;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 3;
    localparam int IMM_W     = 8;

    localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1B0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_INC    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic                 format;
        logic [OPCODE_W-1:0]  opcode;
        logic                 sign;
        logic [OPERAND_W-1:0] operand;
    } instr_t;

    function automatic logic [PC_W-1:0] sext_offset(input logic [OFFSET_W-1:0] off);
        return {{(PC_W-OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel -- combinational next-PC priority mux and adders.
// Priority: jump > branch (only with a valid IR) > stall > increment.
// Ports:
//   pc, ir_pc                 : current fetch PC and PC of the IR instruction
//   ir_valid                  : IR holds a real instruction (qualifies branches)
//   jump_en, jump_target      : absolute redirect
//   branch_taken, branch_offset : PC-relative redirect from ir_pc
//   stall                     : hold request
//   next_pc, sel              : selected next PC and which source won
module pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0]     pc,
    input  logic [PC_W-1:0]     ir_pc,
    input  logic                ir_valid,
    input  logic                jump_en,
    input  logic [PC_W-1:0]     jump_target,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic                stall,
    output logic [PC_W-1:0]     next_pc,
    output pc_sel_t             sel
);

    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] inc_pc;

    // Both adders wrap naturally at 2^16.
    assign branch_pc = ir_pc + sext_offset(branch_offset);
    assign inc_pc    = pc + 16'd1;

    always_comb begin
        next_pc = pc;
        sel     = SEL_HOLD;
        if (jump_en) begin
            next_pc = jump_target;
            sel     = SEL_JUMP;
        end else if (branch_taken && ir_valid) begin
            next_pc = branch_pc;
            sel     = SEL_BRANCH;
        end else if (stall) begin
            next_pc = pc;
            sel     = SEL_HOLD;
        end else begin
            next_pc = inc_pc;
            sel     = SEL_INC;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with IF/ID register.
// Drives pc_out to a combinational ROM, captures instr_in into the IR,
// and handles stall, PC-relative branch and absolute jump redirects.
// Optional macro FETCH_ICOUNT_EN adds the fetch_count output (number of
// instructions loaded into the IR since the last start/reset).
// Ports:
//   clk, reset_n (sync, active low), start (pulse)
//   stall, branch_taken/branch_offset, jump_en/jump_target : pipeline control
//   pc_out -> ROM address, instr_in <- ROM word
//   ir_valid, ir_pc, ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate : IF/ID register
//   halted : high while the FSM is in HALT
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [OFFSET_W-1:0]  branch_offset,
    input  logic                 jump_en,
    input  logic [PC_W-1:0]      jump_target,
    output logic [PC_W-1:0]      pc_out,
    input  logic [INSTR_W-1:0]   instr_in,
    output logic                 ir_valid,
    output logic [PC_W-1:0]      ir_pc,
    output logic                 ir_format,
    output logic [OPCODE_W-1:0]  ir_opcode,
    output logic                 ir_sign,
    output logic [OPERAND_W-1:0] ir_operand,
    output logic [IMM_W-1:0]     ir_immediate,
    output logic                 halted
`ifdef FETCH_ICOUNT_EN
    ,
    output logic [PC_W-1:0]      fetch_count
`endif
);

    state_t          state_reg;
    state_t          state_next;
    logic [PC_W-1:0] pc_reg;
    logic            ir_valid_reg;
    logic [PC_W-1:0] ir_pc_reg;
    instr_t          ir_word_reg;

    logic [PC_W-1:0] pc_next;
    pc_sel_t         pc_sel;
    logic            capture;
    logic            restart;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_reg),
        .ir_pc         (ir_pc_reg),
        .ir_valid      (ir_valid_reg),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .stall         (stall),
        .next_pc       (pc_next),
        .sel           (pc_sel)
    );

    // Control inputs only matter in RUN; start only matters outside RUN.
    assign capture = (state_reg == ST_RUN) && (pc_sel == SEL_INC);
    assign restart = start && (state_reg != ST_RUN);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (capture && (instr_in == HALT_WORD)) state_next = ST_HALT;
            ST_HALT: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        halted = (state_reg == ST_HALT);
    end

    // PC and IF/ID register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_reg       <= '0;
            ir_valid_reg <= 1'b0;
            ir_pc_reg    <= '0;
            ir_word_reg  <= '0;
        end else if (restart) begin
            pc_reg       <= '0;
            ir_valid_reg <= 1'b0;
        end else if (state_reg == ST_HALT) begin
            // The halt word is shown for exactly one cycle, then dropped.
            ir_valid_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            unique case (pc_sel)
                SEL_JUMP, SEL_BRANCH: begin
                    // Redirect squashes the wrong-path fetch.
                    pc_reg       <= pc_next;
                    ir_valid_reg <= 1'b0;
                end
                SEL_INC: begin
                    pc_reg       <= pc_next;
                    ir_valid_reg <= 1'b1;
                    ir_pc_reg    <= pc_reg;
                    ir_word_reg  <= instr_t'(instr_in);
                end
                default: ;
            endcase
        end
    end

    assign pc_out       = pc_reg;
    assign ir_valid     = ir_valid_reg;
    assign ir_pc        = ir_pc_reg;
    assign ir_format    = ir_word_reg.format;
    assign ir_opcode    = ir_word_reg.opcode;
    assign ir_sign      = ir_word_reg.sign;
    assign ir_operand   = ir_word_reg.operand;
    assign ir_immediate = {ir_word_reg.opcode, ir_word_reg.sign, ir_word_reg.operand};

`ifdef FETCH_ICOUNT_EN
    logic [PC_W-1:0] fetch_count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n)
            fetch_count_reg <= '0;
        else if (restart)
            fetch_count_reg <= '0;
        else if (capture)
            fetch_count_reg <= fetch_count_reg + 16'd1;
    end

    assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scenarios plus randomized control traffic,
// checked cycle by cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        jump_en;
    logic [15:0] jump_target;
    logic [15:0] pc_out;
    logic [8:0]  instr_in;
    logic        ir_valid;
    logic [15:0] ir_pc;
    logic        ir_format;
    logic [3:0]  ir_opcode;
    logic        ir_sign;
    logic [2:0]  ir_operand;
    logic [7:0]  ir_immediate;
    logic        halted;
`ifdef FETCH_ICOUNT_EN
    logic [15:0] fetch_count;
`endif

    logic [8:0] rom [0:65535];
    assign instr_in = rom[pc_out];

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .instr_in      (instr_in),
        .ir_valid      (ir_valid),
        .ir_pc         (ir_pc),
        .ir_format     (ir_format),
        .ir_opcode     (ir_opcode),
        .ir_sign       (ir_sign),
        .ir_operand    (ir_operand),
        .ir_immediate  (ir_immediate),
        .halted        (halted)
`ifdef FETCH_ICOUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_irpc;
    logic [8:0]  m_word;
    int          m_loads;

    task automatic model_update();
        logic [8:0] w;
        if (!reset_n) begin
            m_mode = 0; m_pc = 0; m_valid = 0; m_irpc = 0; m_word = 0; m_loads = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_valid = 0; m_loads = 0;
            end else if (m_mode == 2) begin
                m_valid = 0;
            end
        end else if (jump_en) begin
            m_pc = jump_target; m_valid = 0;
        end else if (branch_taken && m_valid) begin
            m_pc = 16'((int'(m_irpc) + int'($signed(branch_offset))) & 32'hFFFF);
            m_valid = 0;
        end else if (!stall) begin
            w = rom[m_pc];
            m_word = w; m_irpc = m_pc; m_valid = 1;
            m_pc = 16'((int'(m_pc) + 1) % 65536);
            m_loads = (m_loads + 1) % 65536;
            if (w == 9'h1B0) m_mode = 2;
        end
    endtask

    // One clock transaction: model advances, DUT sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        n_cyc++;
        check("pc_out", 32'(pc_out), 32'(m_pc));
        check("ir_valid", 32'(ir_valid), 32'(m_valid));
        check("ir_pc", 32'(ir_pc), 32'(m_irpc));
        check("ir_fields", 32'({ir_format, ir_opcode, ir_sign, ir_operand}), 32'(m_word));
        check("ir_immediate", 32'(ir_immediate), 32'(m_word[7:0]));
        check("halted", 32'(halted), 32'(m_mode == 2));
`ifdef FETCH_ICOUNT_EN
        check("fetch_count", 32'(fetch_count), 32'(m_loads));
`endif
        $display("cyc %0d rst_n=%b st=%b stl=%b br=%b jmp=%b pc=%h v=%b ir_pc=%h word=%h halted=%b",
                 n_cyc, reset_n, start, stall, branch_taken, jump_en, pc_out, ir_valid, ir_pc,
                 {ir_format, ir_opcode, ir_sign, ir_operand}, halted);
    endtask

    task automatic quiet();
        reset_n = 1; start = 0; stall = 0; branch_taken = 0; jump_en = 0;
    endtask

    task automatic jump_to(input logic [15:0] t);
        jump_en = 1; jump_target = t;
        step();
        jump_en = 0;
    endtask

    initial begin
        logic [8:0] w;
        for (int i = 0; i < 65536; i++) begin
            w = 9'($urandom_range(0, 511));
            if (w == 9'h1B0) w = 9'h000;
            rom[i] = w;
        end
        rom[0]   = 9'h000;
        rom[131] = 9'h1B0;

        m_mode = 0; m_pc = 0; m_valid = 0; m_irpc = 0; m_word = 0; m_loads = 0;
        quiet();
        branch_offset = 0; jump_target = 0;

        // Reset
        reset_n = 0;
        step(); step();
        check("rst_pc", 32'(pc_out), 0);
        check("rst_valid", 32'(ir_valid), 0);
        check("rst_halted", 32'(halted), 0);
        reset_n = 1;

        // Start and sequential fetch
        start = 1; step(); start = 0;
        check("start_pc", 32'(pc_out), 0);
        check("start_valid", 32'(ir_valid), 0);
        step();
        check("first_valid", 32'(ir_valid), 1);
        check("first_ir_pc", 32'(ir_pc), 0);
        check("seq_pc1", 32'(pc_out), 1);
        step(); check("seq_pc2", 32'(pc_out), 2);
        step(); check("seq_pc3", 32'(pc_out), 3);
        step(); step();
        check("pre_stall_pc", 32'(pc_out), 5);

        // Stall for three cycles
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(pc_out), 5);
            check("stall_ir_pc", 32'(ir_pc), 4);
        end
        stall = 0;
        step(); check("resume_pc", 32'(pc_out), 6);

        // Backward branch from ir_pc 20
        jump_to(16'd20);
        step(); check("br_ir_pc", 32'(ir_pc), 20);
        branch_taken = 1; branch_offset = 8'hF6;
        step(); branch_taken = 0;
        check("br_pc", 32'(pc_out), 10);
        check("br_flush", 32'(ir_valid), 0);
        step();
        jump_en = 1; branch_taken = 1; jump_target = 16'd100; branch_offset = 8'h05;
        step(); quiet();
        check("jump_prio_pc", 32'(pc_out), 100);

        // PC wrap and negative-offset wrap
        jump_to(16'hFFFF);
        step(); check("wrap_pc", 32'(pc_out), 16'h0000);
        jump_to(16'd2);
        step();
        branch_taken = 1; branch_offset = 8'hFC;
        step(); branch_taken = 0;
        check("neg_wrap_pc", 32'(pc_out), 16'hFFFE);

        // Halt at PC 131
        jump_to(16'd131);
        step();
        check("halt_flag", 32'(halted), 1);
        check("halt_pc", 32'(pc_out), 132);
        check("halt_shown", 32'(ir_valid), 1);
        for (int i = 0; i < 3; i++) begin
            stall = 1'($urandom_range(0, 1)); branch_taken = 1;
            jump_en = 1'($urandom_range(0, 1)); jump_target = 16'($urandom);
            step();
            check("halted_pc", 32'(pc_out), 132);
            check("halted_valid", 32'(ir_valid), 0);
        end
        quiet();
        start = 1; step(); start = 0;
        check("restart_pc", 32'(pc_out), 0);
        check("restart_halted", 32'(halted), 0);
        step(); check("restart_run_pc", 32'(pc_out), 1);

        // Randomized traffic
        rom[135] = 9'h1B0;
        for (int i = 0; i < 400; i++) begin
            reset_n       = ($urandom_range(0, 99) != 0);
            start         = ($urandom_range(0, 19) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_offset = 8'($urandom);
            jump_en       = ($urandom_range(0, 11) == 0);
            jump_target   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(120, 140))
                                                        : 16'($urandom);
            step();
        end
        quiet();

        // Reset in the middle of RUN, with stall and jump asserted
        start = 1; step(); start = 0;
        repeat (4) step();
        reset_n = 0; stall = 1; jump_en = 1; jump_target = 16'h1234;
        step();
        check("mid_rst_pc", 32'(pc_out), 0);
        check("mid_rst_valid", 32'(ir_valid), 0);
        check("mid_rst_ir_pc", 32'(ir_pc), 0);
        check("mid_rst_ir", 32'({ir_format, ir_opcode, ir_sign, ir_operand}), 0);
        check("mid_rst_halted", 32'(halted), 0);
`ifdef FETCH_ICOUNT_EN
        check("mid_rst_count", 32'(fetch_count), 0);
`endif
        reset_n = 1;
        // Still IDLE: stall/jump must not move the PC.
        step(); step();
        check("idle_pc", 32'(pc_out), 0);
        check("idle_valid", 32'(ir_valid), 0);
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
